// File: rtl/regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: read ports, write port,
// claim/flush scoreboard controls and status outputs.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         we;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         claim;
  logic [ADDR_WIDTH-1:0]        claim_addr;
  logic                         flush;
  logic                         any_busy;
  logic [DATA_WIDTH-1:0]        dbg_data;

  // master = pipeline (decode/writeback/hazard), slave = register file
  modport master (
    output rd_addr, we, wr_addr, wr_data, claim, claim_addr, flush,
    input  rd_data, rd_busy, any_busy, dbg_data
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, claim, claim_addr, flush,
    output rd_data, rd_busy, any_busy, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read, single-write register file with x0 tied to zero, optional
// write-to-read bypass, and a per-register pending (scoreboard) bit.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int DBG_IDX    = 10
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DBG_A = ADDR_WIDTH'(DBG_IDX);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;

  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_d;
  logic [NUM_RD-1:0]            rd_busy_d;
  logic [ADDR_WIDTH-1:0]        ra;

  always_comb begin
    regs_d = regs_q;
    if (bus.we && bus.wr_addr != '0) regs_d[bus.wr_addr] = bus.wr_data;
    regs_d[0] = '0;
  end

  // Flush beats claim; a claim beats a retiring write to the same register,
  // since the newer instruction now owns it.
  always_comb begin
    pend_d = pend_q;
    if (bus.flush) begin
      pend_d = '0;
    end else begin
      if (bus.we)    pend_d[bus.wr_addr]    = 1'b0;
      if (bus.claim) pend_d[bus.claim_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Reads are gated by rst so a bypassed write cannot leak out during reset.
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    ra        = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (!rst && ra != '0) begin
        if ((BYPASS != 0) && bus.we && bus.wr_addr == ra) begin
          rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
        end else begin
          rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
          rd_busy_d[k]                          = pend_q[ra];
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_d;
  assign bus.rd_busy  = rd_busy_d;
  assign bus.any_busy = |pend_q;
  assign bus.dbg_data = regs_q[DBG_A];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: drives one stimulus stream into a bypassing and a
// non-bypassing instance and checks both against a spec-level model.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic rst;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          claim;
  logic [AW-1:0] claim_addr;
  logic          flush;
  logic [AW-1:0] ra0, ra1;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus1 ();
  regfile_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus0 ();

  assign bus1.rd_addr = {ra1, ra0};
  assign bus1.we = we;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;
  assign bus1.claim = claim;
  assign bus1.claim_addr = claim_addr;
  assign bus1.flush = flush;
  assign bus0.rd_addr = {ra1, ra0};
  assign bus0.we = we;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus0.claim = claim;
  assign bus0.claim_addr = claim_addr;
  assign bus0.flush = flush;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1), .DBG_IDX(10))
    u_byp (.clk(clk), .rst(rst), .bus(bus1));
  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0), .DBG_IDX(10))
    u_nob (.clk(clk), .rst(rst), .bus(bus0));

  // behavioural model: register contents and pending flags
  logic [DW-1:0] m_reg  [32];
  logic          m_pend [32];
  initial for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (flush)                          m_pend[r] = 1'b0;
        else if (claim && claim_addr == r)  m_pend[r] = 1'b1;
        else if (we && wr_addr == r)        m_pend[r] = 1'b0;
      end
      if (we && wr_addr != 0) m_reg[wr_addr] = wr_data;
    end
  end

  function automatic logic [DW-1:0] exp_data(input bit byp, input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (byp && we && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
    if (rst || a == 0) return 1'b0;
    if (byp && we && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic exp_any();
    logic any = 1'b0;
    if (rst) return 1'b0;
    for (int i = 0; i < 32; i++) any |= m_pend[i];
    return any;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // compare process: every falling edge, both instances against the model
  always @(negedge clk) begin
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = (k == 0) ? ra0 : ra1;
      check($sformatf("byp rd_data%0d", k), bus1.rd_data[k*DW +: DW], exp_data(1'b1, a));
      check($sformatf("byp rd_busy%0d", k), DW'(bus1.rd_busy[k]), DW'(exp_busy(1'b1, a)));
      check($sformatf("nob rd_data%0d", k), bus0.rd_data[k*DW +: DW], exp_data(1'b0, a));
      check($sformatf("nob rd_busy%0d", k), DW'(bus0.rd_busy[k]), DW'(exp_busy(1'b0, a)));
    end
    check("byp any_busy", DW'(bus1.any_busy), DW'(exp_any()));
    check("nob any_busy", DW'(bus0.any_busy), DW'(exp_any()));
    check("byp dbg_data", bus1.dbg_data, rst ? '0 : m_reg[10]);
    check("nob dbg_data", bus0.dbg_data, rst ? '0 : m_reg[10]);
  end

  // driver: apply one cycle of inputs just after the edge, return at the falling edge
  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic c, input logic [AW-1:0] ca, input logic f,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(posedge clk);
    #1;
    we = w; wr_addr = wa; wr_data = wd;
    claim = c; claim_addr = ca; flush = f;
    ra0 = r0; ra1 = r1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    we = 0; wr_addr = 0; wr_data = 0; claim = 0; claim_addr = 0; flush = 0;
    ra0 = 0; ra1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset then read
    drive(0, 0, 0, 0, 0, 0, 5'd10, 5'd3);
    check("lit reset rd0", bus1.rd_data[31:0], 32'h0);
    check("lit reset rd1", bus1.rd_data[63:32], 32'h0);
    check("lit reset busy", DW'(bus1.rd_busy), 32'h0);
    check("lit reset any", DW'(bus1.any_busy), 32'h0);
    check("lit reset dbg", bus1.dbg_data, 32'h0);

    // write a0, then a dropped write to x0
    drive(1, 5'd10, 32'hDEADBEEF, 0, 0, 0, 5'd10, 5'd0);
    check("lit byp same-cycle a0", bus1.rd_data[31:0], 32'hDEADBEEF);
    check("lit nob same-cycle a0", bus0.rd_data[31:0], 32'h0);
    check("lit dbg before edge", bus1.dbg_data, 32'h0);
    drive(1, 5'd0, 32'h1234, 0, 0, 0, 5'd10, 5'd0);
    check("lit a0 read", bus1.rd_data[31:0], 32'hDEADBEEF);
    check("lit dbg a0", bus1.dbg_data, 32'hDEADBEEF);
    check("lit x0 read", bus1.rd_data[63:32], 32'h0);

    // bypass on port 1
    drive(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 5'd10, 5'd5);
    check("lit byp port1", bus1.rd_data[63:32], 32'hA5A5A5A5);
    check("lit nob port1 old", bus0.rd_data[63:32], 32'h0);
    drive(0, 0, 0, 0, 0, 0, 5'd10, 5'd5);
    check("lit nob port1 next", bus0.rd_data[63:32], 32'hA5A5A5A5);

    // scoreboard claim / retire on x7
    drive(0, 0, 0, 1, 5'd7, 0, 5'd7, 5'd7);
    check("lit claim same cycle", DW'(bus1.rd_busy), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    check("lit claim next cycle", DW'(bus1.rd_busy), 32'h3);
    check("lit any after claim", DW'(bus1.any_busy), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    drive(1, 5'd7, 32'h55, 0, 0, 0, 5'd7, 5'd0);
    check("lit byp retire busy", DW'(bus1.rd_busy[0]), 32'h0);
    check("lit nob retire busy", DW'(bus0.rd_busy[0]), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    check("lit retired busy", DW'(bus0.rd_busy[0]), 32'h0);
    check("lit retired any", DW'(bus0.any_busy), 32'h0);
    check("lit retired data", bus0.rd_data[31:0], 32'h55);

    // claim/write collision, then claim+flush
    drive(0, 0, 0, 1, 5'd7, 0, 5'd7, 5'd8);
    drive(1, 5'd7, 32'h99, 1, 5'd7, 0, 5'd7, 5'd8);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd8);
    check("lit collide data", bus1.rd_data[31:0], 32'h99);
    check("lit collide busy", DW'(bus1.rd_busy[0]), 32'h1);
    drive(0, 0, 0, 1, 5'd8, 1, 5'd7, 5'd8);
    drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd8);
    check("lit flush busy", DW'(bus1.rd_busy), 32'h0);
    check("lit flush any", DW'(bus1.any_busy), 32'h0);

    // double claim, single retire
    drive(0, 0, 0, 1, 5'd3, 0, 5'd3, 5'd0);
    drive(0, 0, 0, 1, 5'd3, 0, 5'd3, 5'd0);
    drive(1, 5'd3, 32'h33, 0, 0, 0, 5'd3, 5'd0);
    drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
    check("lit double claim cleared", DW'(bus1.rd_busy), 32'h0);

    // async reset between edges
    drive(1, 5'd4, 32'h77, 1, 5'd4, 0, 5'd4, 5'd10);
    drive(0, 0, 0, 0, 0, 0, 5'd4, 5'd10);
    check("lit pre-reset data", bus1.rd_data[31:0], 32'h77);
    check("lit pre-reset busy", DW'(bus1.rd_busy[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("lit async rd_data", bus1.rd_data[31:0], 32'h0);
    check("lit async rd_busy", DW'(bus1.rd_busy), 32'h0);
    check("lit async any", DW'(bus1.any_busy), 32'h0);
    check("lit async dbg", bus1.dbg_data, 32'h0);
    #1 rst = 1'b0;
    drive(1, 5'd10, 32'h1, 0, 0, 0, 5'd4, 5'd10);
    check("lit post-reset dbg old", bus1.dbg_data, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 5'd4, 5'd10);
    check("lit post-reset dbg new", bus1.dbg_data, 32'h1);

    // mixed traffic checked only by the model
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's single-write register file, for the pipelined datapath.
- Configurable number of asynchronous read ports, one synchronous write port, optional write-to-read bypass, and x0 hardwired to zero.
- Holds a per-register pending (scoreboard) bit: set when decode claims a destination, cleared when writeback retires it. The hazard unit uses it to stall.
- Exposes one debug register tap (a0 by default) for the testbench and top-level output.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns old array value
DBG_IDX, 10, register index driven on dbg_data (a0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  read data, packed the same way as rd_addr
rd_busy  out  NUM_RD  1 = addressed register has a write outstanding
we  in  1  write enable
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
claim  in  1  mark claim_addr pending (decode issued an instruction writing it)
claim_addr  in  ADDR_WIDTH  destination being claimed
flush  in  1  clear every pending bit (pipeline flush)
any_busy  out  1  OR of all pending bits
dbg_data  out  DATA_WIDTH  current contents of register DBG_IDX

Behaviour:
Reset
- rst=1 asynchronously clears all registers and all pending bits to 0.
- While rst is high: rd_data = 0, rd_busy = 0, any_busy = 0, dbg_data = 0.
- rst has priority over we, claim and flush.

Writes
- If we=1 and wr_addr != 0, reg[wr_addr] <= wr_data on the rising edge.
- Writes to address 0 are dropped; reg[0] stays 0 permanently.

Reads (combinational, zero latency, per port k)
- If rd_addr_k == 0: rd_data_k = 0 and rd_busy_k = 0.
- Else if BYPASS=1 and we=1 and wr_addr == rd_addr_k: rd_data_k = wr_data and rd_busy_k = 0.
- Else: rd_data_k = reg[rd_addr_k] and rd_busy_k = pend[rd_addr_k].
- With BYPASS=0: rd_data_k = reg[rd_addr_k] and rd_busy_k = pend[rd_addr_k] even during a matching write. The new value and cleared busy appear the next cycle.
- dbg_data = reg[DBG_IDX]; it is never bypassed and changes the cycle after the write.

Scoreboard (pend[], 2**ADDR_WIDTH bits, pend[0] constant 0), next-state priority for register r, highest first:
1. flush=1: pend[r] <= 0 for all r. A claim in the same cycle is also discarded.
2. claim=1, claim_addr == r, r != 0: pend[r] <= 1. This wins over a simultaneous retiring write to the same r, because the newer instruction owns the register.
3. we=1, wr_addr == r: pend[r] <= 0.
4. Otherwise: hold.

Scoreboard timing and edge cases
- A claim is visible on rd_busy the cycle after it is presented; it does not affect the current cycle.
- any_busy is the registered-state OR and does not include same-cycle bypass.
- A write to a non-pending register is legal: the data is stored and pend stays 0.
- Claiming an already-pending register is legal and leaves it at 1. There is no count; one write clears it.
- Reset asserted mid-operation loses all data and pending state. The first edge after deassertion behaves like a normal cycle.
- Any number of read ports may address the same register simultaneously and all return identical data and busy.

Test Plan:
- Reset then read: assert rst, release, drive rd_addr={5'd3,5'd10} -> rd_data=0, rd_busy=0, any_busy=0, dbg_data=0.
- Write/read and x0: we=1, wr_addr=10, wr_data=0xDEADBEEF for 1 cycle, then we=1, wr_addr=0, wr_data=0x1234 -> next cycle port0 on addr 10 reads 0xDEADBEEF, dbg_data=0xDEADBEEF; addr 0 reads 0.
- Bypass: BYPASS=1, we=1, wr_addr=5, wr_data=0xA5A5A5A5, rd_addr port1=5 in the same cycle -> rd_data port1=0xA5A5A5A5 combinationally. With BYPASS=0, the same stimulus returns the old value 0 until the next cycle.
- Scoreboard: claim=1, claim_addr=7 at cycle N -> rd_busy for addr 7 = 0 in N and 1 in N+1, any_busy=1. we=1, wr_addr=7, wr_data=0x55 at N+3 -> rd_busy=0 at N+3 via bypass, pend=0 at N+4, any_busy=0.
- Claim/write collision and flush: pend[7]=1; in one cycle drive claim to 7 and write to 7 with 0x99 -> reg[7]=0x99 and pend[7] still 1. Next, claim 8 plus flush=1 -> all pend 0, any_busy=0.
- Async reset mid-operation: reg[4]=0x77 and pend[4]=1; pulse rst between clock edges -> rd_data for addr 4 = 0 and rd_busy=0 immediately, before the next clk edge.
